// File: rtl/uart_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_pkg
// Description : Shared types and constants for the UART frame parser: FSM
//               state encoding, error codes, byte width and default sync.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_frame_pkg;

  // Width of every byte on the UART side and of the payload stream
  localparam int c_byte_w = 8;

  // Default frame start marker
  localparam logic [c_byte_w-1:0] c_sync_byte_default = 8'hA5;

  // Error causes reported on err_code alongside a frame_err pulse
  localparam logic [1:0] c_err_none     = 2'd0;
  localparam logic [1:0] c_err_bad_len  = 2'd1;
  localparam logic [1:0] c_err_bad_csum = 2'd2;
  localparam logic [1:0] c_err_ovr_to   = 2'd3;

  // Parser states, explicitly encoded
  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CSUM    = 3'd3,
    ST_EMIT    = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/uart_frame_buf.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_buf
// Description : Payload buffer, DEPTH x 8 register file with one synchronous
//               write port and one combinational read port. Contents are not
//               reset; the parser only exposes them while emitting a frame.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_buf
  import uart_frame_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 5
) (
  input  logic                clk,
  input  logic                i_wr_en,
  input  logic [ADDR_W-1:0]   i_wr_addr,
  input  logic [c_byte_w-1:0] i_wr_data,
  input  logic [ADDR_W-1:0]   i_rd_addr,
  output logic [c_byte_w-1:0] o_rd_data
);

  logic [c_byte_w-1:0] r_mem [DEPTH];

  // Store the incoming payload byte into the addressed entry
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_wr_addr == ADDR_W'(i)) begin
          r_mem[i] <= i_wr_data;
        end
      end
    end
  end

  // Read mux; out-of-range addresses return zero instead of X
  always_comb begin
    o_rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_rd_addr == ADDR_W'(i)) begin
        o_rd_data = r_mem[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_frame_parser.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_parser
// Description : Finds SYNC/LEN/payload/CSUM frames in the UART byte strobe,
//               checks length and 8-bit wrapping checksum, buffers the payload
//               and releases good payloads as a ready/valid byte stream.
//               Optional inter-byte timeout: define UART_FRAME_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter int                  MAX_LEN      = 16,
  parameter logic [c_byte_w-1:0] SYNC_BYTE    = c_sync_byte_default,
  parameter int                  TIMEOUT_CLKS = 20000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [c_byte_w-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [c_byte_w-1:0] out_data,
  output logic                out_last,
  output logic                frame_ok,
  output logic                frame_err,
  output logic [1:0]          err_code,
  output logic                busy
);

  localparam int                 c_ptr_w   = $clog2(MAX_LEN + 1);
  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

  // Reject configurations the length field or idle counter cannot represent
  if ((MAX_LEN < 1) || (MAX_LEN > 255) || (TIMEOUT_CLKS < 2)) begin : g_bad_cfg
    $error("uart_frame_parser: MAX_LEN must be 1..255 and TIMEOUT_CLKS >= 2");
  end

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_ptr_w-1:0]  r_len, w_len_nxt;
  logic [c_ptr_w-1:0]  r_wr_ptr, w_wr_ptr_nxt;
  logic [c_ptr_w-1:0]  r_rd_ptr, w_rd_ptr_nxt;
  logic [c_byte_w-1:0] r_acc, w_acc_nxt;
  logic                r_frame_ok, w_frame_ok_nxt;
  logic                r_frame_err, w_frame_err_nxt;
  logic [1:0]          r_err_code, w_err_code_nxt;
  logic                w_buf_we;
  logic [c_byte_w-1:0] w_buf_rd_data;
  logic [c_byte_w-1:0] w_acc_sum;
  logic                w_len_bad;
  logic                w_wr_done;
  logic                w_rd_last;
  logic                w_timeout;

  // Running checksum including the byte currently on the input
  assign w_acc_sum = r_acc + in_data;
  // Zero length or longer than the buffer is rejected
  assign w_len_bad = (in_data == '0) || (in_data > 8'(MAX_LEN));
  // Current payload byte is the LEN-th one
  assign w_wr_done = ((r_wr_ptr + c_ptr_one) == r_len);
  // Read pointer sits on the final payload byte
  assign w_rd_last = (r_rd_ptr == (r_len - c_ptr_one));

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int                  c_idle_w     = $clog2(TIMEOUT_CLKS);
  localparam logic [c_idle_w-1:0] c_idle_limit = c_idle_w'(TIMEOUT_CLKS - 1);
  localparam logic [c_idle_w-1:0] c_idle_one   = c_idle_w'(1);

  logic [c_idle_w-1:0] r_idle;
  logic                w_in_frame;

  // Only the receive states between sync and checksum are guarded
  assign w_in_frame = (r_state == ST_LEN) || (r_state == ST_PAYLOAD) ||
                      (r_state == ST_CSUM);

  // Saturating idle counter, cleared by every byte and outside a frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle <= '0;
    end else if (!w_in_frame || in_valid) begin
      r_idle <= '0;
    end else if (r_idle != '1) begin
      r_idle <= r_idle + c_idle_one;
    end
  end

  // Expiry needs a quiet cycle, so a byte arriving at the limit wins
  assign w_timeout = w_in_frame && !in_valid && (r_idle == c_idle_limit);
`else
  // Without the timeout a truncated frame waits for more bytes or reset
  assign w_timeout = 1'b0;
`endif

  // Next-state, datapath updates and status pulses
  always_comb begin
    w_state_nxt     = r_state;
    w_len_nxt       = r_len;
    w_acc_nxt       = r_acc;
    w_wr_ptr_nxt    = r_wr_ptr;
    w_rd_ptr_nxt    = r_rd_ptr;
    w_frame_ok_nxt  = 1'b0;
    w_frame_err_nxt = 1'b0;
    w_err_code_nxt  = r_err_code;
    w_buf_we        = 1'b0;

    if (w_timeout) begin
      w_frame_err_nxt = 1'b1;
      w_err_code_nxt  = c_err_ovr_to;
      w_state_nxt     = ST_HUNT;
    end else begin
      case (r_state)
        ST_HUNT: begin
          if (in_valid && (in_data == SYNC_BYTE)) begin
            w_state_nxt = ST_LEN;
          end
        end

        ST_LEN: begin
          if (in_valid) begin
            if (w_len_bad) begin
              // The rejected length byte is consumed, never re-tested as sync
              w_frame_err_nxt = 1'b1;
              w_err_code_nxt  = c_err_bad_len;
              w_state_nxt     = ST_HUNT;
            end else begin
              w_len_nxt    = c_ptr_w'(in_data);
              w_acc_nxt    = in_data;
              w_wr_ptr_nxt = '0;
              w_state_nxt  = ST_PAYLOAD;
            end
          end
        end

        ST_PAYLOAD: begin
          if (in_valid) begin
            w_buf_we     = 1'b1;
            w_acc_nxt    = w_acc_sum;
            w_wr_ptr_nxt = r_wr_ptr + c_ptr_one;
            if (w_wr_done) begin
              w_state_nxt = ST_CSUM;
            end
          end
        end

        ST_CSUM: begin
          if (in_valid) begin
            if (w_acc_sum == '0) begin
              w_frame_ok_nxt = 1'b1;
              w_rd_ptr_nxt   = '0;
              w_state_nxt    = ST_EMIT;
            end else begin
              w_frame_err_nxt = 1'b1;
              w_err_code_nxt  = c_err_bad_csum;
              w_state_nxt     = ST_HUNT;
            end
          end
        end

        ST_EMIT: begin
          // The UART cannot be stalled: a byte here is lost but emission goes on
          if (in_valid) begin
            w_frame_err_nxt = 1'b1;
            w_err_code_nxt  = c_err_ovr_to;
          end
          if (out_ready) begin
            if (w_rd_last) begin
              w_state_nxt = ST_HUNT;
            end else begin
              w_rd_ptr_nxt = r_rd_ptr + c_ptr_one;
            end
          end
        end

        default: begin
          w_state_nxt = ST_HUNT;
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Length, pointers, checksum accumulator and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len       <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_acc       <= '0;
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
      r_err_code  <= c_err_none;
    end else begin
      r_len       <= w_len_nxt;
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_acc       <= w_acc_nxt;
      r_frame_ok  <= w_frame_ok_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_err_code  <= w_err_code_nxt;
    end
  end

  uart_frame_buf #(
    .DEPTH  (MAX_LEN),
    .ADDR_W (c_ptr_w)
  ) u_buf (
    .clk       (clk),
    .i_wr_en   (w_buf_we),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (in_data),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_buf_rd_data)
  );

  // Outputs decode straight from the state register so reset clears them at once
  assign out_valid = (r_state == ST_EMIT);
  assign out_data  = w_buf_rd_data;
  assign out_last  = out_valid && w_rd_last;
  assign frame_ok  = r_frame_ok;
  assign frame_err = r_frame_err;
  assign err_code  = r_err_code;
  assign busy      = (r_state != ST_HUNT);

endmodule
`default_nettype wire
